// File: rtl/roberto_pkg.sv
// Shared definitions for the roberto_uc control unit: state codes,
// serial mux select codes and the sensor-skip helper.
package roberto_pkg;

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARA        = 4'd1,
      MEDE           = 4'd2,
      AGUARDA_MEDIDA = 4'd3,
      TRANSMITE      = 4'd4,
      AGUARDA_TX     = 4'd5,
      PROXIMO        = 4'd6,
      FIM            = 4'd7,
      ESPERA         = 4'd8
   } estado_t;

   localparam logic [1:0] SEL_SENSOR1 = 2'd3;
   localparam logic [1:0] SEL_SENSOR2 = 2'd2;
   localparam logic [1:0] SEL_SENSOR3 = 2'd1;
   localparam logic [1:0] SEL_IDLE    = 2'd0;

   localparam logic [1:0] SEL_CENT = 2'd3;
   localparam logic [1:0] SEL_DEZ  = 2'd2;
   localparam logic [1:0] SEL_UNID = 2'd1;
   localparam logic [1:0] SEL_SEP  = 2'd0;

   // Highest sensor select <= sel whose error bit is clear, else SEL_IDLE.
   // Select 3 maps to err[0] (sensor 1), 1 maps to err[2] (sensor 3).
   function automatic logic [1:0] prox_ok(input logic [1:0] sel,
                                          input logic [2:0] err);
      logic [1:0] r;
      r = SEL_IDLE;
      for (int i = 1; i <= 3; i++) begin
         if ((2'(i) <= sel) && !err[3-i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/roberto_temporizador.sv
// Loadable up-counter with clear/enable and compare-equal flag.
// Ports: clock, reset (async low), clr, ld/d, en, limite -> igual.
module roberto_temporizador #(
   parameter int N = 26
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         ld,
   input  logic         en,
   input  logic [N-1:0] d,
   input  logic [N-1:0] limite,
   output logic         igual
);

   logic [N-1:0] q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)  q <= '0;
      else if (clr) q <= '0;
      else if (ld)  q <= d;
      else if (en)  q <= q + 1'b1;
   end

   assign igual = (q == limite);

endmodule

// File: rtl/roberto_uc.sv
// Control unit: clear, measure 3 sensors (with timeout), stream 12 chars.
// Ports: clock, reset (async low), ligar, pronto_medida[2:0], pronto_serial
//        -> zera, medir, partida_tx, sel_sensor, sel_char, erro_medida,
//           pronto, db_estado. Option: ROBERTO_UC_PULA_ERRO_EN skips bad sensors.
module roberto_uc #(
   parameter int T_ESPERA  = 50_000_000,
   parameter int T_TIMEOUT = 2_500_000,
   parameter int N_TMR     = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic [2:0] pronto_medida,
   input  logic       pronto_serial,
   output logic       zera,
   output logic       medir,
   output logic       partida_tx,
   output logic [1:0] sel_sensor,
   output logic [1:0] sel_char,
   output logic [2:0] erro_medida,
   output logic       pronto,
   output logic [3:0] db_estado
);

   import roberto_pkg::*;

   localparam logic [N_TMR-1:0] LIM_ESPERA  = N_TMR'(T_ESPERA - 1);
   localparam logic [N_TMR-1:0] LIM_TIMEOUT = N_TMR'(T_TIMEOUT - 1);

   estado_t          estado;
   logic [2:0]       done;
   logic [2:0]       done_nx;
   logic [2:0]       erro_nx;
   logic [1:0]       sensor_ini;
   logic [1:0]       sensor_prox;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_fim;
   logic [N_TMR-1:0] tmr_lim;

   // Include this cycle's pulses so a late pulse still beats the timeout.
   assign done_nx = done | pronto_medida;
   assign erro_nx = (&done_nx) ? 3'b000 : ~done_nx;

`ifdef ROBERTO_UC_PULA_ERRO_EN
   assign sensor_ini  = prox_ok(SEL_SENSOR1, erro_nx);
   assign sensor_prox = prox_ok(sel_sensor - 2'd1, erro_medida);
`else
   assign sensor_ini  = SEL_SENSOR1;
   assign sensor_prox = sel_sensor - 2'd1;
`endif

   // One timer serves both the measurement timeout and the idle wait.
   assign tmr_clr = (estado == PREPARA) || (estado == FIM);
   assign tmr_en  = (estado == MEDE) || (estado == AGUARDA_MEDIDA)
                 || (estado == ESPERA);
   assign tmr_lim = (estado == ESPERA) ? LIM_ESPERA : LIM_TIMEOUT;

   roberto_temporizador #(.N(N_TMR)) u_tmr (
      .clock  (clock),
      .reset  (reset),
      .clr    (tmr_clr),
      .ld     (1'b0),
      .en     (tmr_en),
      .d      ('0),
      .limite (tmr_lim),
      .igual  (tmr_fim)
   );

   assign db_estado = estado;

   // Pulse outputs are set on the transition into their state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado      <= INICIAL;
         done        <= '0;
         zera        <= 1'b0;
         medir       <= 1'b0;
         partida_tx  <= 1'b0;
         pronto      <= 1'b0;
         sel_sensor  <= SEL_IDLE;
         sel_char    <= SEL_SEP;
         erro_medida <= '0;
      end else begin
         zera       <= 1'b0;
         medir      <= 1'b0;
         partida_tx <= 1'b0;
         pronto     <= 1'b0;
         unique case (estado)
            INICIAL: begin
               if (ligar) begin
                  estado <= PREPARA;
                  zera   <= 1'b1;
               end
            end
            PREPARA: begin
               done        <= '0;
               erro_medida <= '0;
               sel_sensor  <= SEL_IDLE;
               sel_char    <= SEL_SEP;
               estado      <= MEDE;
               medir       <= 1'b1;
            end
            MEDE: begin
               done   <= done_nx;
               estado <= AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
               done <= done_nx;
               if ((&done_nx) || tmr_fim) begin
                  erro_medida <= erro_nx;
                  sel_char    <= SEL_CENT;
                  sel_sensor  <= sensor_ini;
                  if (sensor_ini == SEL_IDLE) begin
                     sel_char <= SEL_SEP;
                     estado   <= FIM;
                     pronto   <= 1'b1;
                  end else begin
                     estado     <= TRANSMITE;
                     partida_tx <= 1'b1;
                  end
               end
            end
            TRANSMITE: begin
               estado <= AGUARDA_TX;
            end
            AGUARDA_TX: begin
               if (pronto_serial) estado <= PROXIMO;
            end
            PROXIMO: begin
               if (sel_char != SEL_SEP) begin
                  sel_char   <= sel_char - 2'd1;
                  estado     <= TRANSMITE;
                  partida_tx <= 1'b1;
               end else if (sensor_prox == SEL_IDLE) begin
                  sel_sensor <= SEL_IDLE;
                  estado     <= FIM;
                  pronto     <= 1'b1;
               end else begin
                  sel_sensor <= sensor_prox;
                  sel_char   <= SEL_CENT;
                  estado     <= TRANSMITE;
                  partida_tx <= 1'b1;
               end
            end
            FIM: begin
               sel_sensor <= SEL_IDLE;
               estado     <= ESPERA;
            end
            ESPERA: begin
               if (tmr_fim) begin
                  if (ligar) begin
                     estado <= PREPARA;
                     zera   <= 1'b1;
                  end else begin
                     estado <= INICIAL;
                  end
               end
            end
            default: estado <= INICIAL;
         endcase
      end
   end

endmodule

// File: tb/tb_roberto_uc.sv
// Self-checking bench for roberto_uc: directed + randomized rounds
// checked against a round-level timing/sequence model.
module tb_roberto_uc;

   localparam int TE = 100;
   localparam int TT = 50;
   localparam int NEVER = 999;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ligar = 1'b0;
   logic [2:0] pronto_medida = 3'b000;
   logic       pronto_serial = 1'b0;
   logic       zera, medir, partida_tx, pronto;
   logic [1:0] sel_sensor, sel_char;
   logic [2:0] erro_medida;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int due = -1;
   int zera_cyc = -1;
   int medir_cyc = -1;
   int pronto_cyc = -1;
   int last_pronto = -1;
   int last_mcyc = -1;
   int p_sel[$];
   int p_cyc[$];

   roberto_uc #(.T_ESPERA(TE), .T_TIMEOUT(TT)) dut (
      .clock         (clock),
      .reset         (reset),
      .ligar         (ligar),
      .pronto_medida (pronto_medida),
      .pronto_serial (pronto_serial),
      .zera          (zera),
      .medir         (medir),
      .partida_tx    (partida_tx),
      .sel_sensor    (sel_sensor),
      .sel_char      (sel_char),
      .erro_medida   (erro_medida),
      .pronto        (pronto),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor plus serial responder: pronto_serial 5 cycles after partida_tx.
   always @(negedge clock) begin
      if (!reset) begin
         due = -1;
         pronto_serial = 1'b0;
      end else begin
         pronto_serial = (cyc == due);
         if (pronto_serial && p_sel.size() > 0)
            chk("sel_stable", {28'd0, sel_sensor, sel_char}, p_sel[$]);
         if (partida_tx) begin
            due = cyc + 5;
            p_sel.push_back(int'({sel_sensor, sel_char}));
            p_cyc.push_back(cyc);
         end
      end
      if (zera)   zera_cyc = cyc;
      if (medir)  medir_cyc = cyc;
      if (pronto) pronto_cyc = cyc;
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   // d[i]: cycle offset of sensor i+1's pulse relative to the medir cycle.
   task automatic run_round(input int d0, input int d1, input int d2,
                            input int exp_medir, input bit drop5);
      int d[3];
      int mcyc, t_exit, tmax, got;
      logic [2:0] err;
      int exp_seq[$];
      d[0] = d0; d[1] = d1; d[2] = d2;
      p_sel.delete();
      p_cyc.delete();
      mcyc = -1;
      for (int k = 0; k < 400; k++) begin
         step();
         if (medir) begin
            mcyc = cyc;
            break;
         end
      end
      chk("medir_seen", (mcyc >= 0), 1);
      if (mcyc < 0) return;
      last_mcyc = mcyc;
      if (exp_medir >= 0) chk("medir_time", mcyc, exp_medir);
      chk("zera_time", zera_cyc, mcyc - 1);
      // Model: a pulse counts when it lands within offsets 0..TT-1.
      err = 3'b000;
      tmax = 1;
      for (int i = 0; i < 3; i++) begin
         if (d[i] <= TT - 1) begin
            if (d[i] > tmax) tmax = d[i];
         end else begin
            err[i] = 1'b1;
         end
      end
      t_exit = (err != 0) ? TT - 1 : tmax;
      for (int s = 0; s < 3; s++) begin
`ifdef ROBERTO_UC_PULA_ERRO_EN
         if (err[s]) continue;
`endif
         for (int c = 3; c >= 0; c--) exp_seq.push_back((3 - s) * 4 + c);
      end
      got = 0;
      for (int off = 0; off < 600; off++) begin
         for (int i = 0; i < 3; i++) pronto_medida[i] = (d[i] == off);
         if (drop5 && p_sel.size() >= 5) ligar = 1'b0;
         if (pronto_cyc >= mcyc) begin
            got = 1;
            break;
         end
         step();
      end
      pronto_medida = 3'b000;
      chk("pronto_seen", got, 1);
      chk("erro_medida", {29'd0, erro_medida}, {29'd0, err});
      chk("sel_idle_fim", {30'd0, sel_sensor}, 0);
      chk("n_chars", p_sel.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < p_sel.size(); i++) begin
         chk($sformatf("char%0d", i), p_sel[i], exp_seq[i]);
         chk($sformatf("char%0d_time", i), p_cyc[i], mcyc + t_exit + 1 + 7 * i);
      end
      chk("pronto_time", pronto_cyc, mcyc + t_exit + 1 + 7 * exp_seq.size());
      last_pronto = pronto_cyc;
   endtask

   initial begin
      int lc, a, b, c, n;
      #1 reset = 1'b0;
      repeat (3) step();
      chk("reset_outs", {17'd0, zera, medir, partida_tx, sel_sensor, sel_char,
                         erro_medida, pronto, db_estado}, 0);
      reset = 1'b1;
      step();
      chk("idle_no_ligar", {28'd0, db_estado}, 0);
      ligar = 1'b1;
      lc = cyc;
      run_round(10, 10, 10, lc + 2, 1'b0);
      run_round(10, NEVER, 10, last_pronto + 102, 1'b0);
      run_round(49, 49, 49, last_pronto + 102, 1'b0);
      run_round(0, 49, 30, last_pronto + 102, 1'b0);
      for (int r = 0; r < 5; r++) begin
         a = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 70);
         b = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 70);
         c = ($urandom_range(0, 3) == 0) ? NEVER : $urandom_range(0, 70);
         run_round(a, b, c, last_pronto + 102, 1'b0);
      end
      run_round(10, 10, 10, last_pronto + 102, 1'b1);
      chk("ligar_dropped", {31'd0, ligar}, 0);
      n = 0;
      while (cyc < last_pronto + 101 && n < 400) begin
         step();
         n++;
      end
      chk("inicial_after_espera", {28'd0, db_estado}, 0);
      repeat (20) step();
      chk("no_new_medir", medir_cyc, last_mcyc);
      // Async reset in the middle of AGUARDA_TX.
      p_sel.delete();
      p_cyc.delete();
      ligar = 1'b1;
      n = 0;
      while (!medir && n < 50) begin
         step();
         n++;
      end
      pronto_medida = 3'b111;
      step();
      pronto_medida = 3'b000;
      n = 0;
      while (p_sel.size() < 1 && n < 50) begin
         step();
         n++;
      end
      chk("pre_reset_tx", (p_sel.size() >= 1), 1);
      step();
      step();
      #2 reset = 1'b0;
      #1;
      chk("async_reset_outs", {17'd0, zera, medir, partida_tx, sel_sensor,
                               sel_char, erro_medida, pronto, db_estado}, 0);
      step();
      reset = 1'b1;
      lc = cyc;
      run_round(5, 5, 5, lc + 2, 1'b0);
      ligar = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
